// File: rtl/sevenseg_pkg.sv
// Shared seven-segment encodings and the leading-zero helper used by the
// sevenseg decoder and the multiplexed display driver.
package sevenseg_pkg;

    localparam int MAX_DIGITS = 16;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

    // Segment a in bit 6 (abcdefg) or in bit 0 (gfedcba), active-high.
    localparam logic [6:0] SEG_ABCDEFG [16] = '{
        7'h7e, 7'h30, 7'h6d, 7'h79, 7'h33, 7'h5b, 7'h5f, 7'h70,
        7'h7f, 7'h7b, 7'h77, 7'h1f, 7'h4e, 7'h3d, 7'h4f, 7'h47
    };
    localparam logic [6:0] SEG_GFEDCBA [16] = '{
        7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
        7'h7f, 7'h6f, 7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71
    };

    function automatic logic [6:0] seg_lookup(input logic [3:0] hex, input logic inverse);
        return inverse ? SEG_GFEDCBA[hex] : SEG_ABCDEFG[hex];
    endfunction

    // Bit i set when digit i and every digit above it are zero; digit 0 never set.
    function automatic logic [MAX_DIGITS-1:0] lz_mask(input logic [4*MAX_DIGITS-1:0] value);
        logic upper_zero;
        lz_mask    = '0;
        upper_zero = 1'b1;
        for (int i = MAX_DIGITS - 1; i > 0; i--) begin
            upper_zero = upper_zero & (value[4*i +: 4] == 4'h0);
            lz_mask[i] = upper_zero;
        end
    endfunction

endpackage

// File: rtl/sevenseg.sv
// Combinational hex to seven-segment decoder with selectable bit order and
// output polarity.
module sevenseg
    import sevenseg_pkg::*;
#(
    parameter int ZERO_IS_ON        = 0,
    parameter int INVERSE_NUMBERING = 0
) (
    input  logic [3:0] in_hex,
    output logic [6:0] out_leds
);

    assign out_leds = seg_lookup(in_hex, INVERSE_NUMBERING != 0) ^ {7{ZERO_IS_ON != 0}};

endmodule

// File: rtl/sevenseg_mux.sv
// Time-multiplexed seven-segment driver: shadowed value/dp, per-slot scan with
// leading blank time, optional leading-zero suppression, registered outputs.
//
// state    | meaning
// ST_BLANK | start of a digit slot, all selects and segments off
// ST_SHOW  | sel[idx] active, segments/dp of digit idx driven
module sevenseg_mux
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS          = 4,
    parameter int MAIN_CLK            = 50_000_000,
    parameter int SCAN_CLK            = 1_000,
    parameter int BLANK_CYCLES        = 16,
    parameter int ZERO_IS_ON          = 0,
    parameter int SEL_ZERO_IS_ON      = 0,
    parameter int INVERSE_NUMBERING   = 0,
    parameter int BLANK_LEADING_ZEROS = 0
) (
    input  logic                    in_clk,
    input  logic                    in_rst_n,
    input  logic [4*NUM_DIGITS-1:0] in_value,
    input  logic [NUM_DIGITS-1:0]   in_dp,
    input  logic                    in_update,
    output logic [6:0]              out_leds,
    output logic                    out_dp,
    output logic [NUM_DIGITS-1:0]   out_sel
);

    localparam int CLK_DIV = MAIN_CLK / SCAN_CLK;
    localparam int PRESC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PRESC_W-1:0]    PRESC_LAST = PRESC_W'(CLK_DIV - 1);
    localparam logic [PRESC_W-1:0]    BLANK_LAST = PRESC_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_OFF    = {7{ZERO_IS_ON != 0}};
    localparam logic                  DP_OFF     = (ZERO_IS_ON != 0);
    localparam logic [NUM_DIGITS-1:0] SEL_OFF    = {NUM_DIGITS{SEL_ZERO_IS_ON != 0}};

    if (NUM_DIGITS < 1 || NUM_DIGITS > MAX_DIGITS) begin : g_bad_num_digits
        $error("sevenseg_mux: NUM_DIGITS out of range");
    end
    if (BLANK_CYCLES < 0 || BLANK_CYCLES >= CLK_DIV) begin : g_bad_blank_cycles
        $error("sevenseg_mux: BLANK_CYCLES must satisfy 0 <= BLANK_CYCLES < CLK_DIV");
    end

    logic [PRESC_W-1:0]      r_presc;
    logic [IDX_W-1:0]        r_idx;
    scan_state_t             r_state;
    logic [4*NUM_DIGITS-1:0] r_val;
    logic [NUM_DIGITS-1:0]   r_dp;
    logic [NUM_DIGITS-1:0]   r_sel;
    logic [6:0]              r_leds;
    logic                    r_dp_out;

    logic                    w_wrap;
    logic [PRESC_W-1:0]      w_presc_next;
    logic [IDX_W-1:0]        w_idx_next;
    scan_state_t             w_state_next;
    logic                    w_show_next;
    logic [4*MAX_DIGITS-1:0] w_val_wide;
    logic [NUM_DIGITS-1:0]   w_lz_mask;
    logic                    w_lz_blank;
    logic [3:0]              w_hex;
    logic [6:0]              w_seg;
    logic [NUM_DIGITS-1:0]   w_sel_hot;

    assign w_wrap       = (r_presc == PRESC_LAST);
    assign w_presc_next = w_wrap ? '0 : r_presc + PRESC_W'(1);
    assign w_idx_next   = !w_wrap              ? r_idx :
                          (r_idx == IDX_LAST)  ? '0    : r_idx + IDX_W'(1);

    always_comb begin
        w_state_next = r_state;
        if (w_wrap) begin
            w_state_next = (BLANK_CYCLES > 0) ? ST_BLANK : ST_SHOW;
        end else if (r_state == ST_BLANK && (BLANK_CYCLES == 0 || r_presc == BLANK_LAST)) begin
            w_state_next = ST_SHOW;
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_presc <= '0;
            r_idx   <= '0;
            r_state <= ST_BLANK;
        end else begin
            r_presc <= w_presc_next;
            r_idx   <= w_idx_next;
            r_state <= w_state_next;
        end
    end

    // Whole-word capture so a slot never mixes old and new nibbles.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_val <= '0;
            r_dp  <= '0;
        end else if (in_update) begin
            r_val <= in_value;
            r_dp  <= in_dp;
        end
    end

    // Output registers are loaded from the next scan position, so select and
    // segments switch together on the same edge as the state register.
    always_comb begin
        w_val_wide = '0;
        w_val_wide[4*NUM_DIGITS-1:0] = r_val;
    end

    assign w_lz_mask   = NUM_DIGITS'(lz_mask(w_val_wide));
    assign w_lz_blank  = (BLANK_LEADING_ZEROS != 0) && w_lz_mask[w_idx_next];
    assign w_hex       = r_val[{w_idx_next, 2'b00} +: 4];
    assign w_show_next = (w_state_next == ST_SHOW);
    assign w_sel_hot   = NUM_DIGITS'(1) << w_idx_next;

    sevenseg #(
        .ZERO_IS_ON        (0),
        .INVERSE_NUMBERING (INVERSE_NUMBERING)
    ) u_dec (
        .in_hex   (w_hex),
        .out_leds (w_seg)
    );

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_sel    <= SEL_OFF;
            r_leds   <= SEG_OFF;
            r_dp_out <= DP_OFF;
        end else begin
            r_sel    <= w_show_next ? (w_sel_hot ^ SEL_OFF) : SEL_OFF;
            r_leds   <= (w_show_next && !w_lz_blank) ? (w_seg ^ SEG_OFF) : SEG_OFF;
            r_dp_out <= w_show_next ? (r_dp[w_idx_next] ^ DP_OFF) : DP_OFF;
        end
    end

    assign out_sel  = r_sel;
    assign out_leds = r_leds;
    assign out_dp   = r_dp_out;

endmodule

// File: tb/tb_sevenseg_mux.sv
// Bench for sevenseg_mux: three parameterisations share stimulus; a slot-arithmetic
// model is compared every cycle, plus literal spot checks of key cycles.
module tb_sevenseg_mux;

    localparam int N  = 4;
    localparam int D  = 10;
    localparam int BC = 2;

    localparam logic [6:0] SEGS [16] = '{
        7'h7e, 7'h30, 7'h6d, 7'h79, 7'h33, 7'h5b, 7'h5f, 7'h70,
        7'h7f, 7'h7b, 7'h77, 7'h1f, 7'h4e, 7'h3d, 7'h4f, 7'h47
    };

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] value = '0;
    logic [3:0]  dp = '0;
    logic        upd = 1'b0;
    logic        chk_on = 1'b0;

    logic [6:0]  a_leds, b_leds, c_leds;
    logic        a_dp, b_dp, c_dp;
    logic [3:0]  a_sel, b_sel, c_sel;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sevenseg_mux #(
        .NUM_DIGITS(N), .MAIN_CLK(1000), .SCAN_CLK(100), .BLANK_CYCLES(BC),
        .ZERO_IS_ON(0), .SEL_ZERO_IS_ON(0), .INVERSE_NUMBERING(0), .BLANK_LEADING_ZEROS(0)
    ) u_dut_a (
        .in_clk(clk), .in_rst_n(rst_n), .in_value(value), .in_dp(dp), .in_update(upd),
        .out_leds(a_leds), .out_dp(a_dp), .out_sel(a_sel)
    );

    sevenseg_mux #(
        .NUM_DIGITS(N), .MAIN_CLK(1000), .SCAN_CLK(100), .BLANK_CYCLES(BC),
        .ZERO_IS_ON(1), .SEL_ZERO_IS_ON(1), .INVERSE_NUMBERING(1), .BLANK_LEADING_ZEROS(0)
    ) u_dut_b (
        .in_clk(clk), .in_rst_n(rst_n), .in_value(value), .in_dp(dp), .in_update(upd),
        .out_leds(b_leds), .out_dp(b_dp), .out_sel(b_sel)
    );

    sevenseg_mux #(
        .NUM_DIGITS(N), .MAIN_CLK(1000), .SCAN_CLK(100), .BLANK_CYCLES(BC),
        .ZERO_IS_ON(0), .SEL_ZERO_IS_ON(0), .INVERSE_NUMBERING(0), .BLANK_LEADING_ZEROS(1)
    ) u_dut_c (
        .in_clk(clk), .in_rst_n(rst_n), .in_value(value), .in_dp(dp), .in_update(upd),
        .out_leds(c_leds), .out_dp(c_dp), .out_sel(c_sel)
    );

    // Model: m_cyc counts edges since reset release; displayed value lags the
    // captured value by one edge.
    int          m_cyc = 0;
    logic [15:0] m_shadow = '0, m_disp = '0;
    logic [3:0]  m_dp_sh = '0, m_dp_disp = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc = 0; m_shadow = '0; m_disp = '0; m_dp_sh = '0; m_dp_disp = '0;
        end else begin
            m_disp    = m_shadow;
            m_dp_disp = m_dp_sh;
            if (upd) begin
                m_shadow = value;
                m_dp_sh  = dp;
            end
            m_cyc++;
        end
    end

    function automatic logic [6:0] rev7(input logic [6:0] s);
        logic [6:0] r;
        for (int i = 0; i < 7; i++) r[i] = s[6-i];
        return r;
    endfunction

    // Returns {sel[3:0], dp, leds[6:0]}.
    function automatic logic [11:0] expect_out(input int pol, input int spol, input int inv,
                                               input int blz, input int n, input logic [15:0] v,
                                               input logic [3:0] dpv, input bit in_reset);
        int          pos;
        int          idx;
        bit          show;
        bit          lz;
        logic [15:0] upper;
        logic [3:0]  sel;
        logic [6:0]  seg;
        logic        d;
        pos   = n % D;
        idx   = (n / D) % N;
        show  = !in_reset && (pos >= BC);
        upper = v >> (4 * idx);
        lz    = (blz != 0) && (idx != 0) && (upper == 16'h0);
        sel   = '0;
        seg   = '0;
        d     = 1'b0;
        if (show) begin
            sel = 4'(1 << idx);
            d   = dpv[idx];
            if (!lz) seg = (inv != 0) ? rev7(SEGS[upper[3:0]]) : SEGS[upper[3:0]];
        end
        if (pol != 0) begin
            seg = ~seg;
            d   = ~d;
        end
        if (spol != 0) sel = ~sel;
        return {sel, d, seg};
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t cyc=%0d: got %h expected %h", name, $time, m_cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("model_A", {a_sel, a_dp, a_leds}, expect_out(0, 0, 0, 0, m_cyc, m_disp, m_dp_disp, !rst_n));
            check("model_B", {b_sel, b_dp, b_leds}, expect_out(1, 1, 1, 0, m_cyc, m_disp, m_dp_disp, !rst_n));
            check("model_C", {c_sel, c_dp, c_leds}, expect_out(0, 0, 0, 1, m_cyc, m_disp, m_dp_disp, !rst_n));
        end
    end

    task automatic wait_cyc(input int n);
        int guard;
        guard = 0;
        while (m_cyc != n && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (m_cyc != n) begin
            total++;
            bad++;
            $display("FAIL wait_cyc: reached %0d expected %0d", m_cyc, n);
        end
    endtask

    task automatic drive_update(input logic [15:0] v, input logic [3:0] d);
        value = v;
        dp    = d;
        upd   = 1'b1;
        @(negedge clk);
        upd   = 1'b0;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1 chk_on = 1'b1;
        @(negedge clk);
        check("rst_A", {a_sel, a_dp, a_leds}, 12'h000);
        check("rst_B", {b_sel, b_dp, b_leds}, 12'hfff);
        check("rst_C", {c_sel, c_dp, c_leds}, 12'h000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        wait_cyc(1);   check("first_blank_A", {a_sel, a_dp, a_leds}, 12'h000);
        wait_cyc(2);   check("first_show_A",  {a_sel, a_dp, a_leds}, 12'h17e);
        drive_update(16'h1234, 4'b0010);
        check("upd_latency_A", {a_sel, a_dp, a_leds}, 12'h17e);
        wait_cyc(4);   check("upd_visible_A", {a_sel, a_dp, a_leds}, 12'h133);
        wait_cyc(5);   check("pol_digit4_B",  {b_sel, b_dp, b_leds}, 12'he99);
        wait_cyc(10);  check("slot_blank_A",  {a_sel, a_dp, a_leds}, 12'h000);
        wait_cyc(12);  check("digit1_A",      {a_sel, a_dp, a_leds}, 12'h2f9);
        wait_cyc(25);  check("digit2_A",      {a_sel, a_dp, a_leds}, 12'h46d);
        wait_cyc(35);  check("digit3_A",      {a_sel, a_dp, a_leds}, 12'h830);
        wait_cyc(42);  check("frame_wrap_A",  {a_sel, a_dp, a_leds}, 12'h133);

        wait_cyc(63);
        drive_update(16'hABCD, 4'b1000);
        check("mid_old_A",     {a_sel, a_dp, a_leds}, 12'h46d);
        wait_cyc(65);  check("mid_new_A",     {a_sel, a_dp, a_leds}, 12'h41f);
        wait_cyc(72);  check("abcd_d3_A",     {a_sel, a_dp, a_leds}, 12'h8f7);
        wait_cyc(82);  check("abcd_d0_A",     {a_sel, a_dp, a_leds}, 12'h13d);

        wait_cyc(119);
        drive_update(16'h0058, 4'b0001);
        check("wrap_blank_A",  {a_sel, a_dp, a_leds}, 12'h000);
        wait_cyc(122);
        check("wrap_new_A",    {a_sel, a_dp, a_leds}, 12'h1ff);
        check("pol_digit8_B",  {b_sel, b_dp, b_leds}, 12'he00);
        wait_cyc(132); check("lz_d1_C",       {c_sel, c_dp, c_leds}, 12'h25b);
        wait_cyc(142);
        check("lz_d2_C",       {c_sel, c_dp, c_leds}, 12'h400);
        check("nolz_d2_A",     {a_sel, a_dp, a_leds}, 12'h47e);
        wait_cyc(152); check("lz_d3_C",       {c_sel, c_dp, c_leds}, 12'h800);

        wait_cyc(159);
        drive_update(16'h0000, 4'b0000);
        wait_cyc(162); check("lz_zero_d0_C",  {c_sel, c_dp, c_leds}, 12'h17e);
        wait_cyc(172);
        check("lz_zero_d1_C",  {c_sel, c_dp, c_leds}, 12'h200);
        check("nolz_zero_A",   {a_sel, a_dp, a_leds}, 12'h27e);

        wait_cyc(175);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_A", {a_sel, a_dp, a_leds}, 12'h000);
        check("async_rst_B", {b_sel, b_dp, b_leds}, 12'hfff);
        check("async_rst_C", {c_sel, c_dp, c_leds}, 12'h000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(1);   check("restart_blank_A", {a_sel, a_dp, a_leds}, 12'h000);
        wait_cyc(2);
        check("restart_d0_A", {a_sel, a_dp, a_leds}, 12'h17e);
        check("restart_d0_B", {b_sel, b_dp, b_leds}, 12'hec0);
        wait_cyc(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
